// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, ALU opcodes, forwarding selects and
// the EX-stage sequencing states.
package cpu_pkg;

   localparam int DATA_W = 64;

   typedef enum logic [2:0] {
      ALU_ADD    = 3'b000,
      ALU_SUB    = 3'b001,
      ALU_AND    = 3'b010,
      ALU_ORR    = 3'b011,
      ALU_EOR    = 3'b100,
      ALU_PASS_B = 3'b101,
      ALU_LSL    = 3'b110,
      ALU_MUL    = 3'b111
   } alu_op_e;

   // Operand source selects driven by the forwarding unit; 2'b11 falls back to FWD_REG.
   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } ex_state_e;

endpackage

// File: rtl/ex_stage_mult_seq.sv
// Iterative shift-add multiplier: one multiplier bit per step, low W bits kept.
// product is combinational so the final step's partial term is included on the done cycle.
module mult_seq #(
   parameter int W = cpu_pkg::DATA_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         step,
   input  logic         abort,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         done,
   output logic [W-1:0] product
);
   import cpu_pkg::*;

   localparam int CW = $clog2(W);

   logic [W-1:0]  mcand;
   logic [W-1:0]  mplier;
   logic [W-1:0]  acc;
   logic [W-1:0]  partial;
   logic [CW-1:0] count;

   assign partial = mplier[0] ? mcand : '0;
   assign product = acc + partial;
   assign done    = step && (count == CW'(W - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         count  <= '0;
      end else if (abort) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         count  <= '0;
      end else if (start) begin
         mcand  <= a;
         mplier <= b;
         acc    <= '0;
         count  <= '0;
      end else if (step) begin
         acc    <= product;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= done ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU with NZCV, a sequenced
// multiply that stalls upstream, and the EX/MEM pipeline register.
module ex_stage #(
   parameter int DATA_W = cpu_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] ID_EX_Da,
   input  logic [DATA_W-1:0] ID_EX_Db,
   input  logic [DATA_W-1:0] ID_EX_Imm,
   input  logic [4:0]        ID_EX_Rw,
   input  logic              ID_EX_RegWrite,
   input  logic              ID_EX_MemWrite,
   input  logic              ID_EX_MemToReg,
   input  logic              ID_EX_ALUSrc,
   input  logic              ID_EX_SetFlags,
   input  logic              ID_EX_Valid,
   input  logic [2:0]        ID_EX_ALUOp,
   input  logic [1:0]        ForwardA,
   input  logic [1:0]        ForwardB,
   input  logic [DATA_W-1:0] MEM_WB_Result,
   input  logic              flush,
   output logic              EX_MEM_RegWrite,
   output logic              EX_MEM_MemWrite,
   output logic              EX_MEM_MemToReg,
   output logic [4:0]        EX_MEM_Rw,
   output logic [DATA_W-1:0] EX_MEM_Result,
   output logic [DATA_W-1:0] EX_MEM_StoreData,
   output logic [3:0]        Flags,
   output logic              ex_busy,
   output logic              dbg_state
);
   import cpu_pkg::*;

   // Handshake: ex_busy=1 means the instruction in ID/EX is not consumed this
   // cycle and upstream must hold it; ex_busy=0 means it retires at the next edge.

   ex_state_e         state;
   alu_op_e           op;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] fwd_b;
   logic [DATA_W-1:0] op_b;
   logic [DATA_W-1:0] b_eff;
   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] alu_res;
   logic              is_sub;
   logic              is_arith;
   logic [3:0]        nzcv;

   logic              is_mul;
   logic              mul_start;
   logic              mul_step;
   logic              mul_abort;
   logic              mul_done;
   logic [DATA_W-1:0] mul_product;
   logic              issue_alu;

   logic [4:0]        mul_rw;
   logic              mul_regwrite;
   logic              mul_memwrite;
   logic              mul_memtoreg;
   logic [DATA_W-1:0] mul_store;

   assign op        = alu_op_e'(ID_EX_ALUOp);
   assign dbg_state = state;

   always_comb begin
      op_a = ID_EX_Da;
      case (ForwardA)
         FWD_MEM: op_a = EX_MEM_Result;
         FWD_WB:  op_a = MEM_WB_Result;
         default: op_a = ID_EX_Da;
      endcase
   end

   always_comb begin
      fwd_b = ID_EX_Db;
      case (ForwardB)
         FWD_MEM: fwd_b = EX_MEM_Result;
         FWD_WB:  fwd_b = MEM_WB_Result;
         default: fwd_b = ID_EX_Db;
      endcase
   end

   assign op_b = ID_EX_ALUSrc ? ID_EX_Imm : fwd_b;

   // SUB runs through the adder as A + ~B + 1 so carry is the not-borrow form.
   assign is_sub   = (op == ALU_SUB);
   assign is_arith = (op == ALU_ADD) || is_sub;
   assign b_eff    = is_sub ? ~op_b : op_b;
   assign sum      = {1'b0, op_a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, is_sub};

   always_comb begin
      alu_res = '0;
      case (op)
         ALU_ADD:    alu_res = sum[DATA_W-1:0];
         ALU_SUB:    alu_res = sum[DATA_W-1:0];
         ALU_AND:    alu_res = op_a & op_b;
         ALU_ORR:    alu_res = op_a | op_b;
         ALU_EOR:    alu_res = op_a ^ op_b;
         ALU_PASS_B: alu_res = op_b;
         ALU_LSL:    alu_res = op_a << op_b[5:0];
         default:    alu_res = '0;
      endcase
   end

   always_comb begin
      nzcv    = '0;
      nzcv[3] = alu_res[DATA_W-1];
      nzcv[2] = (alu_res == '0);
      if (is_arith) begin
         nzcv[1] = sum[DATA_W];
         nzcv[0] = (op_a[DATA_W-1] == b_eff[DATA_W-1]) &&
                   (alu_res[DATA_W-1] != op_a[DATA_W-1]);
      end
   end

   assign is_mul    = (op == ALU_MUL);
   assign mul_start = (state == ST_IDLE) && ID_EX_Valid && !flush && is_mul;
   assign issue_alu = (state == ST_IDLE) && ID_EX_Valid && !flush && !is_mul;
   assign mul_step  = (state == ST_MUL) && !flush;
   assign mul_abort = (state == ST_MUL) && flush;
   assign ex_busy   = mul_start || (mul_step && !mul_done);

   mult_seq #(.W(DATA_W)) u_mult (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_start),
      .step    (mul_step),
      .abort   (mul_abort),
      .a       (op_a),
      .b       (fwd_b),
      .done    (mul_done),
      .product (mul_product)
   );

   // EX/MEM defaults to a bubble every cycle; only a retiring instruction overrides it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= ST_IDLE;
         EX_MEM_RegWrite  <= 1'b0;
         EX_MEM_MemWrite  <= 1'b0;
         EX_MEM_MemToReg  <= 1'b0;
         EX_MEM_Rw        <= '0;
         EX_MEM_Result    <= '0;
         EX_MEM_StoreData <= '0;
         Flags            <= 4'b0000;
         mul_rw           <= '0;
         mul_regwrite     <= 1'b0;
         mul_memwrite     <= 1'b0;
         mul_memtoreg     <= 1'b0;
         mul_store        <= '0;
      end else begin
         EX_MEM_RegWrite  <= 1'b0;
         EX_MEM_MemWrite  <= 1'b0;
         EX_MEM_MemToReg  <= 1'b0;
         EX_MEM_Rw        <= '0;
         EX_MEM_Result    <= '0;
         EX_MEM_StoreData <= '0;
         case (state)
            ST_IDLE: begin
               if (mul_start) begin
                  state        <= ST_MUL;
                  mul_rw       <= ID_EX_Rw;
                  mul_regwrite <= ID_EX_RegWrite;
                  mul_memwrite <= ID_EX_MemWrite;
                  mul_memtoreg <= ID_EX_MemToReg;
                  mul_store    <= fwd_b;
               end else if (issue_alu) begin
                  EX_MEM_RegWrite  <= ID_EX_RegWrite;
                  EX_MEM_MemWrite  <= ID_EX_MemWrite;
                  EX_MEM_MemToReg  <= ID_EX_MemToReg;
                  EX_MEM_Rw        <= ID_EX_Rw;
                  EX_MEM_Result    <= alu_res;
                  EX_MEM_StoreData <= fwd_b;
                  if (ID_EX_SetFlags) begin
                     Flags <= nzcv;
                  end
               end
            end
            ST_MUL: begin
               if (flush) begin
                  state <= ST_IDLE;
               end else if (mul_done) begin
                  state            <= ST_IDLE;
                  EX_MEM_RegWrite  <= mul_regwrite;
                  EX_MEM_MemWrite  <= mul_memwrite;
                  EX_MEM_MemToReg  <= mul_memtoreg;
                  EX_MEM_Rw        <= mul_rw;
                  EX_MEM_Result    <= mul_product;
                  EX_MEM_StoreData <= mul_store;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: the driver pushes hand-computed EX/MEM+Flags
// expectations per issued cycle, and a monitor pops and compares after each edge.
module tb_ex_stage;
   import cpu_pkg::*;

   localparam int W     = 64;
   localparam int EXP_W = 3 + 5 + W + W + 4;
   localparam logic [W-1:0] ONES = '1;

   logic         clk;
   logic         reset;
   logic [W-1:0] ID_EX_Da, ID_EX_Db, ID_EX_Imm;
   logic [4:0]   ID_EX_Rw;
   logic         ID_EX_RegWrite, ID_EX_MemWrite, ID_EX_MemToReg;
   logic         ID_EX_ALUSrc, ID_EX_SetFlags, ID_EX_Valid;
   logic [2:0]   ID_EX_ALUOp;
   logic [1:0]   ForwardA, ForwardB;
   logic [W-1:0] MEM_WB_Result;
   logic         flush;
   logic         EX_MEM_RegWrite, EX_MEM_MemWrite, EX_MEM_MemToReg;
   logic [4:0]   EX_MEM_Rw;
   logic [W-1:0] EX_MEM_Result, EX_MEM_StoreData;
   logic [3:0]   Flags;
   logic         ex_busy;
   logic         dbg_state;

   int n_cmp = 0;
   int n_bad = 0;
   logic [EXP_W-1:0] exp_q[$];
   string            name_q[$];
   logic [3:0]       flg;

   ex_stage #(.DATA_W(W)) dut (
      .clk(clk), .reset(reset),
      .ID_EX_Da(ID_EX_Da), .ID_EX_Db(ID_EX_Db), .ID_EX_Imm(ID_EX_Imm),
      .ID_EX_Rw(ID_EX_Rw), .ID_EX_RegWrite(ID_EX_RegWrite),
      .ID_EX_MemWrite(ID_EX_MemWrite), .ID_EX_MemToReg(ID_EX_MemToReg),
      .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_SetFlags(ID_EX_SetFlags),
      .ID_EX_Valid(ID_EX_Valid), .ID_EX_ALUOp(ID_EX_ALUOp),
      .ForwardA(ForwardA), .ForwardB(ForwardB),
      .MEM_WB_Result(MEM_WB_Result), .flush(flush),
      .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_MemWrite(EX_MEM_MemWrite),
      .EX_MEM_MemToReg(EX_MEM_MemToReg), .EX_MEM_Rw(EX_MEM_Rw),
      .EX_MEM_Result(EX_MEM_Result), .EX_MEM_StoreData(EX_MEM_StoreData),
      .Flags(Flags), .ex_busy(ex_busy), .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [EXP_W-1:0] pk(input logic rwr, input logic mw, input logic m2r,
                                           input logic [4:0] rw, input logic [W-1:0] res,
                                           input logic [W-1:0] sd, input logic [3:0] fl);
      return {rwr, mw, m2r, rw, res, sd, fl};
   endfunction

   function automatic logic [EXP_W-1:0] bubble(input logic [3:0] fl);
      return pk(1'b0, 1'b0, 1'b0, 5'd0, '0, '0, fl);
   endfunction

   function automatic logic [EXP_W-1:0] actual();
      return pk(EX_MEM_RegWrite, EX_MEM_MemWrite, EX_MEM_MemToReg, EX_MEM_Rw,
                EX_MEM_Result, EX_MEM_StoreData, Flags);
   endfunction

   task automatic check_vec(input string name, input logic [EXP_W-1:0] act, input logic [EXP_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual {rw,mw,m2r,rd,res,sd,nzcv}=%h required=%h", name, act, exp);
      end
   endtask

   task automatic check_busy(input string name, input logic exp);
      n_cmp++;
      if (ex_busy !== exp) begin
         n_bad++;
         $display("FAIL %s ex_busy: actual=%b required=%b", name, ex_busy, exp);
      end
   endtask

   // driver tasks
   task automatic set_in(input logic [2:0] op, input logic [W-1:0] da, input logic [W-1:0] db,
                         input logic [W-1:0] imm, input logic [4:0] rw, input logic rwr,
                         input logic mw, input logic m2r, input logic src, input logic sf,
                         input logic [1:0] fa, input logic [1:0] fb);
      ID_EX_ALUOp = op; ID_EX_Da = da; ID_EX_Db = db; ID_EX_Imm = imm; ID_EX_Rw = rw;
      ID_EX_RegWrite = rwr; ID_EX_MemWrite = mw; ID_EX_MemToReg = m2r;
      ID_EX_ALUSrc = src; ID_EX_SetFlags = sf; ForwardA = fa; ForwardB = fb;
      ID_EX_Valid = 1'b1; flush = 1'b0;
   endtask

   // Called just after a falling edge with inputs already set.
   task automatic tick(input string name, input logic busy_e, input logic [EXP_W-1:0] e);
      #1;
      check_busy(name, busy_e);
      exp_q.push_back(e);
      name_q.push_back(name);
      @(negedge clk);
   endtask

   // scoreboard monitor
   initial begin
      logic [EXP_W-1:0] e;
      string            nm;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check_vec(nm, actual(), e);
         end
      end
   end

   initial begin
      reset = 1'b1;
      set_in(3'b000, 64'd9, 64'd9, 64'd9, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
      MEM_WB_Result = '0;
      flg = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      check_vec("reset_state", actual(), bubble(4'b0000));
      @(negedge clk);
      reset = 1'b0;

      // op, Da, Db, Imm, Rw, RegWrite, MemWrite, MemToReg, ALUSrc, SetFlags, FwdA, FwdB
      set_in(ALU_ADD, 64'd5, 64'd0, 64'd7, 5'd3, 1, 0, 0, 1, 0, FWD_REG, FWD_REG);
      tick("add_imm", 1'b0, pk(1, 0, 0, 5'd3, 64'd12, 64'd0, flg));
      set_in(ALU_ADD, 64'd20, 64'd0, 64'd0, 5'd1, 1, 0, 0, 1, 0, FWD_REG, FWD_REG);
      tick("add_20", 1'b0, pk(1, 0, 0, 5'd1, 64'd20, 64'd0, flg));
      set_in(ALU_SUB, 64'd99, 64'd20, 64'd0, 5'd2, 1, 0, 0, 0, 1, FWD_MEM, FWD_REG);
      flg = 4'b0110;
      tick("sub_fwd_mem", 1'b0, pk(1, 0, 0, 5'd2, 64'd0, 64'd20, flg));
      MEM_WB_Result = 64'hFF;
      set_in(ALU_ADD, 64'h100, 64'h55, 64'd8, 5'd0, 0, 1, 1, 1, 0, FWD_REG, FWD_WB);
      tick("store_fwd_wb", 1'b0, pk(0, 1, 1, 5'd0, 64'h108, 64'hFF, flg));
      set_in(ALU_ADD, 64'h100, 64'h55, 64'd8, 5'd0, 0, 1, 0, 1, 0, FWD_REG, 2'b11);
      tick("store_fwd_11", 1'b0, pk(0, 1, 0, 5'd0, 64'h108, 64'h55, flg));
      MEM_WB_Result = 64'h10;
      set_in(ALU_AND, 64'hABC, 64'h18, 64'd0, 5'd4, 1, 0, 0, 0, 1, FWD_WB, FWD_REG);
      flg = 4'b0000;
      tick("and_fwd_wb", 1'b0, pk(1, 0, 0, 5'd4, 64'h10, 64'h18, flg));
      set_in(ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 5'd5, 1, 0, 0, 0, 1, FWD_REG, FWD_REG);
      flg = 4'b1001;
      tick("add_ovf", 1'b0, pk(1, 0, 0, 5'd5, 64'h8000_0000_0000_0000, 64'd1, flg));
      set_in(ALU_ADD, ONES, 64'd1, 64'd0, 5'd5, 1, 0, 0, 0, 1, FWD_REG, FWD_REG);
      flg = 4'b0110;
      tick("add_carry", 1'b0, pk(1, 0, 0, 5'd5, 64'd0, 64'd1, flg));
      set_in(ALU_ORR, 64'hF0, 64'h0F, 64'd0, 5'd6, 1, 0, 0, 0, 0, FWD_REG, FWD_REG);
      tick("orr_noflags", 1'b0, pk(1, 0, 0, 5'd6, 64'hFF, 64'h0F, flg));
      set_in(ALU_EOR, 64'hFF, 64'h0F, 64'd0, 5'd6, 1, 0, 0, 0, 1, FWD_REG, FWD_REG);
      flg = 4'b0000;
      tick("eor", 1'b0, pk(1, 0, 0, 5'd6, 64'hF0, 64'h0F, flg));
      set_in(ALU_PASS_B, 64'd0, 64'd0, 64'h8000_0000_0000_0001, 5'd8, 1, 0, 0, 1, 1, FWD_REG, FWD_REG);
      flg = 4'b1000;
      tick("pass_b", 1'b0, pk(1, 0, 0, 5'd8, 64'h8000_0000_0000_0001, 64'd0, flg));
      set_in(ALU_LSL, 64'd1, 64'h43, 64'd0, 5'd9, 1, 0, 0, 0, 0, FWD_REG, FWD_REG);
      tick("lsl_3", 1'b0, pk(1, 0, 0, 5'd9, 64'd8, 64'h43, flg));
      set_in(ALU_LSL, 64'd3, 64'd63, 64'd0, 5'd9, 1, 0, 0, 0, 0, FWD_REG, FWD_REG);
      tick("lsl_63", 1'b0, pk(1, 0, 0, 5'd9, 64'h8000_0000_0000_0000, 64'd63, flg));
      set_in(ALU_SUB, 64'd3, 64'd5, 64'd0, 5'd10, 1, 0, 0, 0, 1, FWD_REG, FWD_REG);
      flg = 4'b1000;
      tick("sub_borrow", 1'b0, pk(1, 0, 0, 5'd10, 64'hFFFF_FFFF_FFFF_FFFE, 64'd5, flg));
      set_in(ALU_ADD, 64'd1, 64'd1, 64'd0, 5'd11, 1, 0, 0, 0, 1, FWD_REG, FWD_REG);
      ID_EX_Valid = 1'b0;
      tick("invalid", 1'b0, bubble(flg));
      set_in(ALU_MUL, 64'd3, 64'd5, 64'd0, 5'd7, 1, 0, 0, 0, 1, FWD_REG, FWD_REG);
      flush = 1'b1;
      tick("flush_idle_mul", 1'b0, bubble(flg));

      // 3 x 5: one start cycle, 63 busy steps, then retirement on the 65th edge
      set_in(ALU_MUL, 64'd3, 64'd5, 64'd0, 5'd7, 1, 0, 0, 0, 1, FWD_REG, FWD_REG);
      tick("mul_start", 1'b1, bubble(flg));
      for (int i = 0; i < 63; i++) tick("mul_busy", 1'b1, bubble(flg));
      tick("mul_3x5", 1'b0, pk(1, 0, 0, 5'd7, 64'd15, 64'd5, flg));

      set_in(ALU_MUL, ONES, 64'd2, 64'd0, 5'd12, 1, 0, 0, 0, 0, FWD_REG, FWD_REG);
      tick("mul2_start", 1'b1, bubble(flg));
      for (int i = 0; i < 63; i++) tick("mul2_busy", 1'b1, bubble(flg));
      tick("mul_ones_x2", 1'b0, pk(1, 0, 0, 5'd12, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, flg));

      // flush arriving at count=10 aborts the multiply within the same cycle
      set_in(ALU_MUL, 64'd7, 64'd9, 64'd0, 5'd13, 1, 0, 0, 0, 0, FWD_REG, FWD_REG);
      tick("mul3_start", 1'b1, bubble(flg));
      for (int i = 0; i < 10; i++) tick("mul3_busy", 1'b1, bubble(flg));
      flush = 1'b1;
      tick("mul_flush", 1'b0, bubble(flg));
      set_in(ALU_ADD, 64'd1, 64'd1, 64'd0, 5'd14, 1, 0, 0, 0, 0, FWD_REG, FWD_REG);
      tick("add_after_flush", 1'b0, pk(1, 0, 0, 5'd14, 64'd2, 64'd1, flg));

      // reset mid-multiply: immediate bubble and cleared flags, no late product
      set_in(ALU_MUL, 64'd6, 64'd6, 64'd0, 5'd15, 1, 0, 0, 0, 0, FWD_REG, FWD_REG);
      tick("mul4_start", 1'b1, bubble(flg));
      for (int i = 0; i < 4; i++) tick("mul4_busy", 1'b1, bubble(flg));
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      flg = 4'b0000;
      check_vec("reset_mid_mul", actual(), bubble(flg));
      @(negedge clk);
      @(negedge clk);
      ID_EX_Valid = 1'b0;
      reset = 1'b0;
      for (int i = 0; i < 66; i++) tick("post_reset_idle", 1'b0, bubble(flg));
      set_in(ALU_ADD, 64'd2, 64'd2, 64'd0, 5'd16, 1, 0, 0, 0, 1, FWD_REG, FWD_REG);
      tick("add_after_reset", 1'b0, pk(1, 0, 0, 5'd16, 64'd4, 64'd2, flg));
      ID_EX_Valid = 1'b0;

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: actual pending=%0d required=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter: DATA_W, default 64, datapath width in bits.
REQ-002 clk  in  1  pipeline clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 ID_EX_Da, ID_EX_Db, ID_EX_Imm  in  DATA_W each  register-file operands and extended immediate.
REQ-005 ID_EX_Rw  in  5  destination register; ID_EX_RegWrite, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_ALUSrc, ID_EX_SetFlags, ID_EX_Valid  in  1 each  control bits.
REQ-006 ID_EX_ALUOp  in  3  operation: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 PASS_B, 110 LSL, 111 MUL.
REQ-007 ForwardA, ForwardB  in  2 each  operand source select from the forwarding unit.
REQ-008 MEM_WB_Result  in  DATA_W  writeback-stage value for forwarding.
REQ-009 flush  in  1  squash instruction currently in EX.
REQ-010 EX_MEM_RegWrite, EX_MEM_MemWrite, EX_MEM_MemToReg  out  1 each; EX_MEM_Rw  out  5; EX_MEM_Result, EX_MEM_StoreData  out  DATA_W  registered EX/MEM fields.
REQ-011 Flags  out  4  registered NZCV; ex_busy  out  1  combinational stall request to upstream stages.

Function
REQ-012 Operand A SHALL be EX_MEM_Result when ForwardA=2'b10, MEM_WB_Result when 2'b01, ID_EX_Da otherwise (2'b11 treated as 2'b00); operand B likewise with ForwardB/ID_EX_Db.
REQ-013 EX_MEM_StoreData SHALL register forwarded operand B; the ALU B input SHALL be ID_EX_Imm when ID_EX_ALUSrc=1, else forwarded B.
REQ-014 ADD/SUB/AND/ORR/EOR/PASS_B SHALL produce DATA_W-bit results modulo 2^DATA_W; LSL SHALL shift A left by B[5:0].
REQ-015 Single-cycle ops SHALL have 1-cycle latency: result and control registered at the edge ending the EX cycle.
REQ-016 NZCV SHALL be computed for ADD/SUB only (C = carry-out, SUB as A+~B+1; V = signed overflow); logic ops SHALL set N,Z and clear C,V; Flags SHALL update only when ID_EX_Valid=1, ID_EX_SetFlags=1, flush=0, ex_busy=0.
REQ-017 State machine IDLE/MUL: in IDLE with valid MUL and flush=0, ex_busy=1, forwarded operands SHALL be captured, next state MUL with count=0.
REQ-018 In MUL, one multiplier bit per cycle (shift-add, low DATA_W bits of product); ex_busy=1 while count<63, ex_busy=0 when count=63.
REQ-019 At the edge ending count=63 the EX/MEM register SHALL load the product and the MUL instruction's control fields; state returns to IDLE; total EX occupancy 65 cycles.
REQ-020 Whenever ex_busy=1, EX/MEM SHALL load a bubble; upstream holds ID/EX stable.
REQ-021 Bubble: RegWrite=0, MemWrite=0, MemToReg=0, Rw=0, Result=0, StoreData=0.
REQ-022 ID_EX_Valid=0 or flush=1 SHALL load a bubble and leave Flags unchanged.
REQ-023 flush=1 in MUL SHALL abort the multiply, clear count, return to IDLE, deassert ex_busy combinationally in that cycle.
REQ-024 MUL never sets Flags.

Reset
REQ-025 reset=1 SHALL immediately force all EX/MEM outputs to the bubble value, Flags=4'b0000, state IDLE, count=0, capture registers 0.
REQ-026 Reset mid-multiply SHALL discard the operation; no partial result reaches EX/MEM.

Structure
REQ-027 Shared package cpu_pkg SHALL hold DATA_W, the ALU-op enum, and forward-select constants (FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10).
REQ-028 The iterative multiplier SHALL be a sub-module mult_seq (start, operands, done, product); muxes, ALU, FSM control and EX/MEM register stay in ex_stage.

Verification
REQ-029 ADD Da=5, Imm=7, ALUSrc=1, Rw=3, RegWrite=1 -> next edge EX_MEM_Result=12, Rw=3, RegWrite=1.
REQ-030 ForwardA=2'b10, prior EX_MEM_Result=20, SUB B=20, SetFlags=1 -> Result=0, Flags=0110 (Z=1, C=1).
REQ-031 ForwardB=2'b01, MEM_WB_Result=0xFF, MemWrite=1 -> EX_MEM_StoreData=0xFF; with ForwardB=2'b11 -> StoreData=ID_EX_Db.
REQ-032 MUL A=3, B=5 -> ex_busy high 64 cycles, bubbles in EX/MEM, on 65th edge Result=15; A=all-ones, B=2 -> Result=all-ones minus 1.
REQ-033 flush during MUL at count=10 -> IDLE, ex_busy=0 same cycle, bubble loaded; reset asserted mid-MUL -> outputs bubble immediately, Flags=0.
